// File: rtl/ingress_xfer_arbiter.sv
// ingress_xfer_arbiter: grants one pending ingress port (strict priority, round-robin ties)
// and muxes its payload stream onto a single 16-bit output bus.
module ingress_xfer_arbiter #(
    parameter int NPORT   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NPORT-1:0]    new_packet,
    input  logic [3*NPORT-1:0]  prior_in,
    input  logic [9*NPORT-1:0]  length_in,
    input  logic [4*NPORT-1:0]  dest_in,
    input  logic [NPORT-1:0]    data_vld_in,
    input  logic [16*NPORT-1:0] data_in,
    output logic [NPORT-1:0]    xfer_stop,
    output logic                out_vld,
    output logic [15:0]         out_data,
    output logic                out_sop,
    output logic                out_eop,
    output logic [3:0]          out_dest,
    output logic [2:0]          out_prior,
    output logic                busy,
    output logic [NPORT-1:0]    err_ovf,
    output logic [NPORT-1:0]    err_tmo
);
    localparam int PW = $clog2(NPORT);
    typedef enum logic [1:0] {IDLE, GRANT, XFER} state_t;

    logic [NPORT-1:0][2:0]  prior_a;
    logic [NPORT-1:0][8:0]  len_a;
    logic [NPORT-1:0][3:0]  dest_a;
    logic [NPORT-1:0][15:0] data_a;
    assign prior_a = prior_in;
    assign len_a   = length_in;
    assign dest_a  = dest_in;
    assign data_a  = data_in;

    state_t                state_q, state_d;
    logic [NPORT-1:0]      pend_q, pend_d;
    logic [NPORT-1:0][2:0] prior_q, prior_d;
    logic [NPORT-1:0][8:0] len_q, len_d;
    logic [NPORT-1:0][3:0] dest_q, dest_d;
    logic [PW-1:0]         gnt_q, gnt_d, rr_q, rr_d, win, gnt_nxt;
    logic [8:0]            cnt_q, cnt_d;
    logic [6:0]            idle_q, idle_d;
    logic [NPORT-1:0]      stop_q, stop_d, ovf_q, ovf_d, tmo_q, tmo_d;
    logic                  out_vld_q, out_vld_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
    logic [15:0]           out_data_q, out_data_d;
    logic [3:0]            out_dest_q, out_dest_d;
    logic [2:0]            out_prior_q, out_prior_d;
    logic [2:0]            best;
    logic                  found, acc, rel;
    int                    idx;

    // Scan from rr_ptr upward; a strictly higher priority is needed to displace an earlier hit.
    always_comb begin
        win   = rr_q;
        best  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NPORT; k++) begin
            idx = (int'(rr_q) + k) % NPORT;
            if (pend_q[idx] && (!found || prior_q[idx] > best)) begin
                found = 1'b1;
                best  = prior_q[idx];
                win   = PW'(idx);
            end
        end
    end

    assign gnt_nxt = (gnt_q == PW'(NPORT - 1)) ? '0 : gnt_q + 1'b1;
    assign acc     = (state_q == XFER) && data_vld_in[gnt_q] && !stop_q[gnt_q];

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        prior_d     = prior_q;
        len_d       = len_q;
        dest_d      = dest_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        stop_d      = stop_q;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        out_vld_d   = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_data_d  = out_data_q;
        out_dest_d  = out_dest_q;
        out_prior_d = out_prior_q;
        rel         = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            if (new_packet[i]) begin
                if (pend_q[i]) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    pend_d[i]  = 1'b1;
                    prior_d[i] = prior_a[i];
                    len_d[i]   = len_a[i];
                    dest_d[i]  = dest_a[i];
                end
            end
        end
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d       = win;
                    cnt_d       = len_q[win];
                    out_dest_d  = dest_q[win];
                    out_prior_d = prior_q[win];
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                idle_d = '0;
                if (cnt_q == '0) begin
                    rel = 1'b1;
                end else begin
                    stop_d[gnt_q] = 1'b0;
                    state_d       = XFER;
                end
            end
            XFER: begin
                if (acc) begin
                    out_vld_d  = 1'b1;
                    out_data_d = data_a[gnt_q];
                    out_sop_d  = cnt_q == len_q[gnt_q];
                    out_eop_d  = cnt_q == 9'd1;
                    rel        = cnt_q == 9'd1;
                    cnt_d      = cnt_q - 1'b1;
                    idle_d     = '0;
                end else if (idle_q == 7'(TIMEOUT - 1)) begin
                    out_eop_d    = 1'b1;
                    tmo_d[gnt_q] = 1'b1;
                    rel          = 1'b1;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Release overrides a same-cycle header for the granted port (already flagged as overflow above).
        if (rel) begin
            state_d       = IDLE;
            pend_d[gnt_q] = 1'b0;
            stop_d        = '1;
            rr_d          = gnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            prior_q     <= '0;
            len_q       <= '0;
            dest_q      <= '0;
            gnt_q       <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            stop_q      <= '1;
            ovf_q       <= '0;
            tmo_q       <= '0;
            out_vld_q   <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
            out_dest_q  <= '0;
            out_prior_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            prior_q     <= prior_d;
            len_q       <= len_d;
            dest_q      <= dest_d;
            gnt_q       <= gnt_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            stop_q      <= stop_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            out_vld_q   <= out_vld_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
            out_dest_q  <= out_dest_d;
            out_prior_q <= out_prior_d;
        end
    end

    assign xfer_stop = stop_q;
    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_dest  = out_dest_q;
    assign out_prior = out_prior_q;
    assign busy      = state_q != IDLE;
    assign err_ovf   = ovf_q;
    assign err_tmo   = tmo_q;
endmodule
